// File: rtl/piso_frame_pkg.sv
// piso_frame_pkg: framing constants shared by the transmitter and matching receiver
package piso_frame_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
endpackage

// File: rtl/piso_frame_tx.sv
// piso_frame_tx: LSB-first framed serialiser (start, data, optional even parity, stop)
module piso_frame_tx import piso_frame_pkg::*; #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] cnt;
  logic par;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = din_valid ? ST_START : ST_IDLE;
      ST_START:  state_nx = en ? ST_DATA : ST_START;
      ST_DATA:   state_nx = (en && cnt == CW'(WIDTH - 1)) ? (PARITY_EN ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY: state_nx = en ? ST_STOP : ST_PARITY;
      ST_STOP:   state_nx = en ? ST_IDLE : ST_STOP;
      default:   state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state == ST_STOP && en;
      if (state == ST_IDLE && din_valid) begin
        shreg <= din;
        par   <= ^din;
        cnt   <= '0;
      end else if (state == ST_DATA && en) begin
        shreg <= shreg >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end
  assign sout = state == ST_START  ? START_BIT :
                state == ST_DATA   ? shreg[0]  :
                state == ST_PARITY ? par       : LINE_IDLE;
  assign din_ready = state == ST_IDLE;
  assign busy      = state != ST_IDLE;
endmodule

// File: tb/tb_piso_frame_tx.sv
// tb_piso_frame_tx: directed checks of parity and no-parity builds sharing one stimulus
module tb_piso_frame_tx;
  logic clk = 1'b0, rst, en, din_valid;
  logic [3:0] din;
  logic din_ready, sout, busy, done;
  logic din_ready2, sout2, busy2, done2;
  int tests = 0, fails = 0;

  piso_frame_tx #(.WIDTH(4), .PARITY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .sout(sout), .busy(busy), .done(done));
  piso_frame_tx #(.WIDTH(4), .PARITY_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
    .din_ready(din_ready2), .sout(sout2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // e[i] / e2[i] is the expected line level i cycles after the load edge
  task automatic run_frame(input logic [3:0] w, input logic [6:0] e, input logic [5:0] e2);
    din = w;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("sout", sout, e[i]);
      chk("busy", busy, 1'b1);
      chk("din_ready_low", din_ready, 1'b0);
      chk("done_low", done, 1'b0);
      if (i < 6) chk("sout_nopar", sout2, e2[i]);
      else chk("done_nopar", done2, 1'b1);
      tick;
    end
    chk("done_pulse", done, 1'b1);
    chk("idle_sout", sout, 1'b1);
    chk("idle_busy", busy, 1'b0);
    tick;
    chk("done_cleared", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; din_valid = 1'b0; din = 4'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_sout", sout, 1'b1);
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    run_frame(4'b1011, 7'b1110110, 6'b110110);
    run_frame(4'b0000, 7'b1000000, 6'b100000);
    run_frame(4'b0111, 7'b1101110, 6'b101110);

    // slow tick: each bit of 1100 (0,0,0,1,1,0,1) held for exactly 4 cycles
    en = 1'b0;
    din = 4'b1100;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 7; i++)
      for (int k = 0; k < 4; k++) begin
        en = (k == 3);
        chk("slow_sout", sout, logic'(7'b1011000 >> i));
        tick;
      end
    en = 1'b1;
    chk("slow_done", done, 1'b1);
    tick;

    // din keeps changing while valid stays high; the loaded word must be transmitted
    din = 4'b1011;
    din_valid = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) begin
      din = 4'(i * 5 + 2);
      chk("hs_sout", sout, logic'(7'b1110110 >> i));
      chk("hs_ready_low", din_ready, 1'b0);
      tick;
    end
    chk("hs_gap_ready", din_ready, 1'b1);
    chk("hs_gap_sout", sout, 1'b1);
    chk("hs_gap_done", done, 1'b1);
    din = 4'b0111;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("b2b_sout", sout, logic'(7'b1101110 >> i));
      tick;
    end
    chk("b2b_done", done, 1'b1);
    tick;

    // en low mid-DATA freezes the frame
    din = 4'b1011;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      chk("frz_sout", sout, logic'(7'b1110110 >> i));
      if (i == 2) begin
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
          tick;
          chk("frz_hold_sout", sout, 1'b1);
          chk("frz_hold_busy", busy, 1'b1);
          chk("frz_hold_done", done, 1'b0);
        end
        en = 1'b1;
      end
      tick;
    end
    chk("frz_done", done, 1'b1);
    tick;

    // reset mid-frame aborts without a done pulse
    din = 4'b1011;
    din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("abort_sout", sout, 1'b1);
    chk("abort_ready", din_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready_nopar", din_ready2, 1'b1);
    chk("abort_busy_nopar", busy2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_done_nopar", done2, 1'b0);
      chk("abort_idle_sout", sout, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
